buzzer_tone_gen: RTL



---
 rtl/buzzer_tone_gen.sv | 112 +++++++++++
 1 files changed

// File: rtl/buzzer_tone_gen.sv
// rtl/buzzer_tone_gen.sv - ASCII key to square-wave buzzer driver with glitch-free note changes
// Optional feature macro: BUZZER_OCTAVE_EN (adds octave_up, halves loaded half-period)
module buzzer_tone_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 17
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [6:0]   ascii,
`ifdef BUZZER_OCTAVE_EN
  input  logic         octave_up,
`endif
  output logic         buzz,
  output logic         playing,
  output logic [6:0]   cur_key
);

  typedef enum logic [0:0] {IDLE, PLAY} state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   counter, counter_n;
  logic               buzz_n;
  logic [6:0]         cur_key_n;
  logic [6:0]         pending;
  logic [DIV_W-1:0]   pend_half;
  logic [DIV_W-1:0]   load_half;
  logic               pend_mapped;

  // Zero half-period marks an unmapped key, which doubles as the silence flag.
  function automatic logic [DIV_W-1:0] half_of(input logic [6:0] key);
    case (key)
      7'd97:   half_of = DIV_W'(CLK_HZ / (2 * 262));
      7'd115:  half_of = DIV_W'(CLK_HZ / (2 * 294));
      7'd100:  half_of = DIV_W'(CLK_HZ / (2 * 330));
      7'd102:  half_of = DIV_W'(CLK_HZ / (2 * 349));
      7'd103:  half_of = DIV_W'(CLK_HZ / (2 * 392));
      7'd104:  half_of = DIV_W'(CLK_HZ / (2 * 440));
      7'd106:  half_of = DIV_W'(CLK_HZ / (2 * 494));
      7'd107:  half_of = DIV_W'(CLK_HZ / (2 * 523));
      default: half_of = '0;
    endcase
  endfunction

  // The request seen on the boundary edge itself decides the next phase, so
  // the latest value within a half-period always wins.
  assign pending     = enable ? ascii : 7'd0;
  assign pend_half   = half_of(pending);
  assign pend_mapped = |pend_half;

`ifdef BUZZER_OCTAVE_EN
  assign load_half = octave_up ? (pend_half >> 1) : pend_half;
`else
  assign load_half = pend_half;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      counter <= '0;
      buzz    <= 1'b0;
      cur_key <= 7'd0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      buzz    <= buzz_n;
      cur_key <= cur_key_n;
    end
  end

  always_comb begin
    state_n   = state;
    counter_n = counter;
    buzz_n    = buzz;
    cur_key_n = cur_key;
    case (state)
      IDLE: begin
        buzz_n = 1'b0;
        if (pend_mapped) begin
          buzz_n    = 1'b1;
          counter_n = load_half - DIV_W'(1);
          cur_key_n = pending;
          state_n   = PLAY;
        end
      end
      PLAY: begin
        if (counter != '0) begin
          counter_n = counter - DIV_W'(1);
        end else if (pend_mapped) begin
          buzz_n    = ~buzz;
          counter_n = load_half - DIV_W'(1);
          cur_key_n = pending;
        end else begin
          // Silence only lands on a boundary, so the last high phase is never cut.
          buzz_n    = 1'b0;
          counter_n = '0;
          cur_key_n = 7'd0;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n   = IDLE;
        buzz_n    = 1'b0;
        counter_n = '0;
        cur_key_n = 7'd0;
      end
    endcase
  end

  assign playing = (state == PLAY);

endmodule
